mem_bus_if: RTL
===============

MEM_BUS_IF -- requirements
Module: mem_bus_if

Interface
REQ-001 Parameter: TIMEOUT_CYC, 16, max BUS-state cycles awaiting bus_ack before abort.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  M-stage memory instruction present.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_size  input  2  0 = word, 1 = half, 2 = byte; 3 is reserved and treated as word.
REQ-008 req_wdata  input  32  store data, right-aligned.
REQ-009 req_ldop  input  3  load-extend code: lw=0, lbu=1, lb=2, lhu=3, lh=4.
REQ-010 stall  output  1  freezes the pipeline while an access is outstanding.
REQ-011 bus_req, bus_we  output  1 each  bus request strobe and write flag.
REQ-012 bus_addr  output  32  word address, {req_addr[31:2], 2'b00}.
REQ-013 bus_byteen  output  4  write lane enables; 0000 on loads.
REQ-014 bus_wdata  output  32  lane-replicated store data.
REQ-015 bus_ack  input  1  one-cycle completion pulse; bus_rdata is valid in the same cycle.
REQ-016 bus_rdata  input  32  raw read word.
REQ-017 resp_valid  output  1  one-cycle pulse when the access completes.
REQ-018 resp_word, resp_a, resp_op  output  32/2/3  raw word, addr[1:0] and ldop, forwarded to the downstream load extender.
REQ-019 exc_adel, exc_ades, exc_bus  output  1 each  load-misalign, store-misalign and timeout exception pulses.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUS and RESP.
REQ-021 In IDLE with req_valid and an aligned address, the block SHALL latch all req_* fields, go to BUS next cycle, and hold stall=1 combinationally in the accept cycle.
REQ-022 Alignment rules: word needs addr[1:0]=00; half needs addr[0]=0; byte is always aligned.
REQ-023 A misaligned request in IDLE SHALL pulse exc_adel (load) or exc_ades (store) in the same cycle, hold stall=0, issue no bus request, and stay in IDLE.
REQ-024 In BUS, the block SHALL drive bus_req=1 and hold the bus_* outputs constant from the latched fields, with stall=1.
REQ-025 On bus_ack in BUS, the block SHALL register bus_rdata into resp_word and go to RESP.
REQ-026 In RESP, the block SHALL drive resp_valid=1 and stall=0 for exactly one cycle, then go to IDLE.
REQ-027 req_valid seen during RESP SHALL be ignored; the next request is accepted only from IDLE.
REQ-028 On a store, resp_word SHALL equal bus_rdata as sampled and carry no meaning.
REQ-029 Byte enables SHALL be: word 1111; half 0011 when addr[1]=0, else 1100; byte 0001 shifted left by addr[1:0].
REQ-030 bus_wdata SHALL be: word as-is; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
REQ-031 A wait counter SHALL clear on entry to BUS and increment each BUS cycle without ack.
REQ-032 When the wait counter reaches TIMEOUT_CYC-1 without ack, the block SHALL pulse exc_bus for one cycle, drop bus_req, go to IDLE, and hold stall=0 in that cycle.
REQ-033 If bus_ack arrives in the same cycle as the timeout, the ack SHALL win and no exc_bus is raised.
REQ-034 bus_ack outside BUS SHALL be ignored.

Reset
REQ-035 Reset SHALL place the FSM in IDLE, clear the wait counter, and drive every output to 0, including resp_word, resp_a and resp_op.
REQ-036 Reset asserted in BUS or RESP SHALL abort the access at that edge: bus_req=0 from the next cycle, and no resp_valid or exception pulse.

Structure
REQ-037 A shared package SHALL hold the size encodings, the ldop encodings (lw..lh) and the state enum; the downstream extender reuses the ldop encodings.
REQ-038 The lane logic (byte enables and wdata replication) SHALL be a combinational sub-module named mem_lane_gen.

Verification
REQ-039 sw to 0x1000 with data 0xDEADBEEF, ack on the 3rd BUS cycle -> byteen 1111, wdata 0xDEADBEEF, stall high 4 cycles, then a resp_valid pulse.
REQ-040 sb to 0x1003 with data 0x000000A5 -> bus_addr 0x1000, byteen 1000, wdata 0xA5A5A5A5.
REQ-041 lh from 0x2001 -> exc_adel pulse, stall 0, bus_req never asserted.
REQ-042 lbu from 0x3002 with rdata 0x11223344 -> resp_word 0x11223344, resp_a 2, resp_op 1.
REQ-043 lw with no ack and TIMEOUT_CYC=16 -> exc_bus after 16 BUS cycles, FSM back in IDLE; a second run with ack in cycle 16 -> resp_valid and no exc_bus.
REQ-044 Reset pulsed on the 2nd BUS cycle, then a late ack -> no resp_valid, all outputs 0.

Source files
------------

// File: rtl/mem_bus_if_pkg.sv
// Shared encodings for the M-stage memory bus interface and the downstream load extender.
// Holds access sizes, load-extend ops, the FSM state type and the alignment rule.
package mem_bus_if_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;  // decodes as a word access

    localparam logic [2:0] LDOP_LW  = 3'd0;
    localparam logic [2:0] LDOP_LBU = 3'd1;
    localparam logic [2:0] LDOP_LB  = 3'd2;
    localparam logic [2:0] LDOP_LHU = 3'd3;
    localparam logic [2:0] LDOP_LH  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_HALF: ok = ~addr_lo[0];
            SZ_BYTE: ok = 1'b1;
            default: ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_bus_if_if.sv
// Request, bus and response signals of the memory bus interface.
// The block sits on the slave modport; the pipeline/bus environment on the master modport.
interface mem_bus_if_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic [2:0]  req_ldop;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        resp_valid;
    logic [31:0] resp_word;
    logic [1:0]  resp_a;
    logic [2:0]  resp_op;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_bus;

    // Handshake: a request is taken only in IDLE when req_valid is high and the address is
    // aligned; bus_req stays high until the single-cycle bus_ack pulse (or the timeout cycle);
    // resp_valid and exc_* are one-cycle pulses with no back-pressure.
    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata, req_ldop, bus_ack, bus_rdata,
        output stall, bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
               resp_valid, resp_word, resp_a, resp_op, exc_adel, exc_ades, exc_bus
    );

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata, req_ldop, bus_ack, bus_rdata,
        input  stall, bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
               resp_valid, resp_word, resp_a, resp_op, exc_adel, exc_ades, exc_bus
    );
endinterface

// File: rtl/mem_lane_gen.sv
// Store lane generation: byte enables and lane-replicated write data from size and addr[1:0].
// Reserved size 3 falls into the word branch.
module mem_lane_gen
    import mem_bus_if_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_byteen,
    output logic [31:0] o_wdata
);

    always_comb begin
        o_byteen = 4'b1111;
        o_wdata  = i_wdata;
        case (i_size)
            SZ_HALF: begin
                o_byteen = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata  = {2{i_wdata[15:0]}};
            end
            SZ_BYTE: begin
                o_byteen = 4'b0001 << i_addr_lo;
                o_wdata  = {4{i_wdata[7:0]}};
            end
            default: begin
                o_byteen = 4'b1111;
                o_wdata  = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_if.sv
// M-stage memory bus interface: accepts one aligned load/store, runs it on the bus with a
// bounded wait, and hands the raw read word to the load extender.
module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    mem_bus_if_if.slave bif,
    output state_e      o_dbg_state
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);

    state_e        r_state;
    logic [CW-1:0] r_wait;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [1:0]    r_size;
    logic [31:0]   r_wdata;
    logic [2:0]    r_ldop;
    logic [31:0]   r_resp_word;

    logic          w_aligned;
    logic          w_accept;
    logic          w_misalign;
    logic          w_timeout;
    logic          w_bus_act;
    logic [3:0]    w_byteen;
    logic [31:0]   w_wdata;

    assign w_aligned  = is_aligned(bif.req_size, bif.req_addr[1:0]);
    assign w_accept   = (r_state == ST_IDLE) && bif.req_valid && w_aligned;
    assign w_misalign = (r_state == ST_IDLE) && bif.req_valid && !w_aligned;
    // An ack in the last allowed cycle beats the timeout.
    assign w_timeout  = (r_state == ST_BUS) && !bif.bus_ack && (r_wait == WAIT_LAST);
    assign w_bus_act  = (r_state == ST_BUS) && !w_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wait      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_size      <= SZ_WORD;
            r_wdata     <= '0;
            r_ldop      <= LDOP_LW;
            r_resp_word <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we    <= bif.req_we;
                        r_addr  <= bif.req_addr;
                        r_size  <= bif.req_size;
                        r_wdata <= bif.req_wdata;
                        r_ldop  <= bif.req_ldop;
                        r_wait  <= '0;
                        r_state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (bif.bus_ack) begin
                        r_resp_word <= bif.bus_rdata;
                        r_state     <= ST_RESP;
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    mem_lane_gen u_lane (
        .i_size    (r_size),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .o_byteen  (w_byteen),
        .o_wdata   (w_wdata)
    );

    assign bif.stall      = w_accept || w_bus_act;
    assign bif.bus_req    = w_bus_act;
    assign bif.bus_we     = w_bus_act && r_we;
    assign bif.bus_addr   = w_bus_act ? {r_addr[31:2], 2'b00} : 32'h0;
    assign bif.bus_byteen = (w_bus_act && r_we) ? w_byteen : 4'b0000;
    assign bif.bus_wdata  = w_bus_act ? w_wdata : 32'h0;
    assign bif.resp_valid = (r_state == ST_RESP);
    assign bif.resp_word  = r_resp_word;
    assign bif.resp_a     = r_addr[1:0];
    assign bif.resp_op    = r_ldop;
    assign bif.exc_adel   = w_misalign && !bif.req_we;
    assign bif.exc_ades   = w_misalign && bif.req_we;
    assign bif.exc_bus    = w_timeout;
    assign o_dbg_state    = r_state;

endmodule
